// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : definitions_pkg
//  Description : Shared constants and types for the Canny stream transmitter.
//                IMAGE_WIDTH / IMAGE_HEIGHT give the default frame geometry;
//                tx_entry_t is one buffered pixel with its frame tags.
//  Revision    : 1.0  initial release
// ============================================================================
package definitions_pkg;

   localparam int IMAGE_WIDTH  = 640;
   localparam int IMAGE_HEIGHT = 480;
   localparam int PIXEL_W      = 8;

   // One buffered pixel: {eof, sof, eol, data}
   typedef struct packed {
      logic               eof;
      logic               sof;
      logic               eol;
      logic [PIXEL_W-1:0] data;
   } tx_entry_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO, parameterised width and depth (power of
//                two). The head entry is presented combinationally on dout;
//                there is no write-to-read bypass, so a pushed entry becomes
//                visible the cycle after it is written.
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                push, din  - write strobe / data (ignored while full)
//                pop, dout  - read strobe (ignored while empty) / head data
//                full, empty, count - occupancy from the registered count
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int c_addr_w = $clog2(DEPTH);
   localparam int c_cnt_w  = c_addr_w + 1;

   logic [WIDTH-1:0]    r_mem [DEPTH];
   logic [c_addr_w-1:0] r_wr_ptr;
   logic [c_addr_w-1:0] r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                w_do_push;
   logic                w_do_pop;

   assign full      = (r_count == c_cnt_w'(DEPTH));
   assign empty     = (r_count == '0);
   assign count     = r_count;
   assign dout      = r_mem[r_rd_ptr];
   assign w_do_push = push && !full;
   assign w_do_pop  = pop && !empty;

   // Storage carries no reset; only pointers and count define validity.
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_do_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/canny_stream_tx.sv
`default_nettype none
// ============================================================================
//  Module      : canny_stream_tx
//  Description : Converts the Canny pipeline's valid-only edge stream into an
//                AXI-Stream master. Pixels are tagged with frame geometry
//                (sof/eol/eof), buffered in a FIFO and re-emitted through a
//                single output register honouring m_tready. Pixels arriving
//                while the FIFO is full are dropped and flagged.
//  Ports       : clk, rst                 - clock, async active-high reset
//                pixel_in, pixel_in_valid - incoming edge pixels (no ready)
//                m_tdata/m_tvalid/m_tready/m_tuser/m_tlast - AXI-Stream out
//                overflow                 - sticky drop indicator
//                frame_done               - pulse after the eof beat is taken
//                ovf_count                - drop counter, only when
//                                           CANNY_TX_OVF_COUNT_EN is defined
//  Revision    : 1.0  initial release
// ============================================================================
module canny_stream_tx
   import definitions_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int IMG_WIDTH  = IMAGE_WIDTH,
   parameter int IMG_HEIGHT = IMAGE_HEIGHT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   pixel_in,
   input  logic         pixel_in_valid,
   output logic [7:0]   m_tdata,
   output logic         m_tvalid,
   input  logic         m_tready,
   output logic         m_tuser,
   output logic         m_tlast,
   output logic         overflow,
   output logic         frame_done
`ifdef CANNY_TX_OVF_COUNT_EN
   ,
   output logic [15:0]  ovf_count
`endif
);

   localparam int c_col_w = $clog2(IMG_WIDTH);
   localparam int c_row_w = $clog2(IMG_HEIGHT + 1);
   localparam int c_cnt_w = $clog2(FIFO_DEPTH) + 1;
   localparam int c_ent_w = $bits(tx_entry_t);

   logic [c_col_w-1:0] r_col;
   logic [c_row_w-1:0] r_row;
   logic               w_col_last;
   logic               w_row_last;
   tx_entry_t          w_entry;
   tx_entry_t          w_head;
   tx_entry_t          r_out;
   logic               r_out_valid;
   logic               r_overflow;
   logic               r_frame_done;
   logic               w_full;
   logic               w_empty;
   logic [c_cnt_w-1:0] w_count;
   logic               w_push;
   logic               w_drop;
   logic               w_hs;
   logic               w_load;

   // ---------------------------------------------------------------------
   // Geometry counters advance on every valid pixel, dropped or not, so the
   // tags stay aligned with the true frame position after an overflow.
   // ---------------------------------------------------------------------
   assign w_col_last = (r_col == c_col_w'(IMG_WIDTH - 1));
   assign w_row_last = (r_row == c_row_w'(IMG_HEIGHT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_col <= '0;
         r_row <= '0;
      end else if (pixel_in_valid) begin
         if (w_col_last) begin
            r_col <= '0;
            r_row <= w_row_last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

   always_comb begin
      w_entry      = '0;
      w_entry.data = pixel_in;
      w_entry.sof  = (r_col == '0) && (r_row == '0);
      w_entry.eol  = w_col_last;
      w_entry.eof  = w_col_last && w_row_last;
   end

   // ---------------------------------------------------------------------
   // FIFO. Acceptance looks only at the registered count, so a push that
   // lands on a full FIFO is dropped even if a pop frees a slot that cycle.
   // ---------------------------------------------------------------------
   assign w_push = pixel_in_valid && (w_count < c_cnt_w'(FIFO_DEPTH));
   assign w_drop = pixel_in_valid && w_full;

   sync_fifo #(
      .WIDTH (c_ent_w),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .din   (w_entry),
      .pop   (w_load),
      .dout  (w_head),
      .full  (w_full),
      .empty (w_empty),
      .count (w_count)
   );

   // ---------------------------------------------------------------------
   // Output register: refills when empty or when its beat is being taken.
   // ---------------------------------------------------------------------
   assign w_hs   = r_out_valid && m_tready;
   assign w_load = !w_empty && (!r_out_valid || m_tready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out       <= '0;
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out       <= w_head;
         r_out_valid <= 1'b1;
      end else if (w_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_overflow   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
         r_frame_done <= w_hs && r_out.eof;
      end
   end

`ifdef CANNY_TX_OVF_COUNT_EN
   logic [15:0] r_ovf_count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ovf_count <= '0;
      end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
         r_ovf_count <= r_ovf_count + 16'd1;
      end
   end

   assign ovf_count = r_ovf_count;
`endif

   assign m_tdata    = r_out.data;
   assign m_tuser    = r_out.sof;
   assign m_tlast    = r_out.eol;
   assign m_tvalid   = r_out_valid;
   assign overflow   = r_overflow;
   assign frame_done = r_frame_done;

endmodule
`default_nettype wire
